// File: rtl/reset_sequencer.sv
// Power-on / soft reset sequencer: waits for a synchronized PLL lock, holds reset for a
// settling window, then releases peripherals ahead of the core and flags the domain ready.
module reset_sequencer #(
  parameter int SYNC_STAGES     = 2,
  parameter int STABLE_CYCLES   = 16,
  parameter int PERIPH_LEAD     = 4,
  parameter int SOFT_RST_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_lock,
  input  logic sw_reset_req,
  output logic periph_rst,
  output logic core_rst,
  output logic clk_ready,
  output logic lock_lost
);

  localparam int MAX_AB = (STABLE_CYCLES > PERIPH_LEAD) ? STABLE_CYCLES : PERIPH_LEAD;
  localparam int MAX_CYCLES = (MAX_AB > SOFT_RST_CYCLES) ? MAX_AB : SOFT_RST_CYCLES;
  localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] LEAD_LAST   = CW'(PERIPH_LEAD - 1);
  localparam logic [CW-1:0] SOFT_LAST   = CW'(SOFT_RST_CYCLES - 1);

  typedef enum logic [2:0] {
    WAIT_LOCK,
    STABLE,
    PERIPH,
    RUN,
    SOFT
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  state_t                 state;
  state_t                 state_nx;
  logic [CW-1:0]          count;
  logic [CW-1:0]          count_nx;
  logic                   from_soft;
  logic                   from_soft_nx;
  logic                   lost_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
    end
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  // Loss of lock overrides everything; the shared counter is always cleared on a state change.
  always_comb begin
    state_nx     = state;
    count_nx     = count;
    from_soft_nx = from_soft;
    lost_nx      = lock_lost;
    if (!lock_s) begin
      state_nx     = WAIT_LOCK;
      count_nx     = '0;
      from_soft_nx = 1'b0;
      if (state == PERIPH || state == RUN || state == SOFT) begin
        lost_nx = 1'b1;
      end
    end else begin
      case (state)
        WAIT_LOCK: begin
          state_nx = STABLE;
          count_nx = '0;
        end
        STABLE: begin
          if (count == STABLE_LAST) begin
            state_nx     = PERIPH;
            count_nx     = '0;
            from_soft_nx = 1'b0;
          end else begin
            count_nx = count + CW'(1);
          end
        end
        PERIPH: begin
          if (count == LEAD_LAST) begin
            state_nx = RUN;
            count_nx = '0;
          end else begin
            count_nx = count + CW'(1);
          end
        end
        RUN: begin
          count_nx = '0;
          if (sw_reset_req) begin
            state_nx = SOFT;
          end
        end
        SOFT: begin
          if (count == SOFT_LAST) begin
            state_nx     = PERIPH;
            count_nx     = '0;
            from_soft_nx = 1'b1;
          end else begin
            count_nx = count + CW'(1);
          end
        end
        default: begin
          state_nx = WAIT_LOCK;
          count_nx = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they switch on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= WAIT_LOCK;
      count      <= '0;
      from_soft  <= 1'b0;
      periph_rst <= 1'b1;
      core_rst   <= 1'b1;
      clk_ready  <= 1'b0;
      lock_lost  <= 1'b0;
    end else begin
      state      <= state_nx;
      count      <= count_nx;
      from_soft  <= from_soft_nx;
      periph_rst <= (state_nx == WAIT_LOCK) || (state_nx == STABLE) || (state_nx == SOFT);
      core_rst   <= (state_nx != RUN);
      clk_ready  <= (state_nx == RUN) || (state_nx == SOFT) ||
                    ((state_nx == PERIPH) && from_soft_nx);
      lock_lost  <= lost_nx;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed timing scenarios followed by random
// lock/request traffic, all compared every cycle against a deadline-based reference model.
module tb_reset_sequencer;

  localparam int SYNC_STAGES     = 2;
  localparam int STABLE_CYCLES   = 16;
  localparam int PERIPH_LEAD     = 4;
  localparam int SOFT_RST_CYCLES = 8;

  localparam int M_IDLE   = 0;
  localparam int M_COUNT  = 1;
  localparam int M_PERIPH = 2;
  localparam int M_RUN    = 3;
  localparam int M_SOFT   = 4;

  logic clock;
  logic reset;
  logic pllLock;
  logic swResetReq;
  logic periphRst;
  logic coreRst;
  logic clkReady;
  logic lockLost;

  int checks;
  int failures;

  int  edgeNum;
  int  mode;
  int  deadline;
  bit  fromSoft;
  bit  mLost;
  bit  lockPipe [SYNC_STAGES];

  reset_sequencer #(
    .SYNC_STAGES(SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES),
    .PERIPH_LEAD(PERIPH_LEAD),
    .SOFT_RST_CYCLES(SOFT_RST_CYCLES)
  ) dut (
    .clk(clock),
    .rst(reset),
    .pll_lock(pllLock),
    .sw_reset_req(swResetReq),
    .periph_rst(periphRst),
    .core_rst(coreRst),
    .clk_ready(clkReady),
    .lock_lost(lockLost)
  );

  // 10-unit clock period, rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %b expected %b at time %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic void modelReset();
    mode     = M_IDLE;
    deadline = 0;
    fromSoft = 1'b0;
    mLost    = 1'b0;
    for (int i = 0; i < SYNC_STAGES; i++) lockPipe[i] = 1'b0;
  endfunction

  // Behaviour expressed as absolute deadlines: each timed phase ends a fixed number of
  // edges after the edge that entered it.
  function automatic void modelStep();
    bit lockSeen;
    edgeNum++;
    lockSeen = lockPipe[SYNC_STAGES-1];
    if (!lockSeen) begin
      if (mode == M_PERIPH || mode == M_RUN || mode == M_SOFT) mLost = 1'b1;
      mode = M_IDLE;
    end else begin
      case (mode)
        M_IDLE: begin
          mode     = M_COUNT;
          deadline = edgeNum + STABLE_CYCLES;
        end
        M_COUNT: if (edgeNum == deadline) begin
          mode     = M_PERIPH;
          fromSoft = 1'b0;
          deadline = edgeNum + PERIPH_LEAD;
        end
        M_PERIPH: if (edgeNum == deadline) mode = M_RUN;
        M_RUN: if (swResetReq) begin
          mode     = M_SOFT;
          deadline = edgeNum + SOFT_RST_CYCLES;
        end
        M_SOFT: if (edgeNum == deadline) begin
          mode     = M_PERIPH;
          fromSoft = 1'b1;
          deadline = edgeNum + PERIPH_LEAD;
        end
        default: mode = M_IDLE;
      endcase
    end
    for (int i = SYNC_STAGES - 1; i > 0; i--) lockPipe[i] = lockPipe[i-1];
    lockPipe[0] = pllLock;
  endfunction

  // One clock edge: advance the model with the inputs the DUT sampled, then compare.
  task automatic applyStimulus();
    @(posedge clock);
    if (reset) modelReset();
    else modelStep();
    #1;
    checkOutput("periph_rst", periphRst, (mode == M_IDLE || mode == M_COUNT || mode == M_SOFT));
    checkOutput("core_rst", coreRst, (mode != M_RUN));
    checkOutput("clk_ready", clkReady,
                (mode == M_RUN || mode == M_SOFT || (mode == M_PERIPH && fromSoft)));
    checkOutput("lock_lost", lockLost, mLost);
  endtask

  task automatic pulseReset();
    pllLock = 1'b0;
    reset   = 1'b1;
    applyStimulus();
    applyStimulus();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus();
  endtask

  initial begin
    int softEntries;
    logic prevPeriph;
    checks     = 0;
    failures   = 0;
    edgeNum    = 0;
    reset      = 1'b1;
    pllLock    = 1'b0;
    swResetReq = 1'b0;
    modelReset();

    for (int i = 0; i < 3; i++) applyStimulus();
    reset = 1'b0;
    for (int i = 0; i < 50; i++) applyStimulus();

    // Power-up: edge 1 is the first edge sampling lock high.
    pllLock = 1'b1;
    for (int e = 1; e <= 26; e++) begin
      applyStimulus();
      if (e == 18) checkOutput("pu_periph_e18", periphRst, 1'b1);
      if (e == 19) checkOutput("pu_periph_e19", periphRst, 1'b0);
      if (e == 22) checkOutput("pu_core_e22", coreRst, 1'b1);
      if (e == 23) checkOutput("pu_core_e23", coreRst, 1'b0);
      if (e == 23) checkOutput("pu_ready_e23", clkReady, 1'b1);
    end

    // Single-cycle soft request sampled at edge k.
    swResetReq = 1'b1;
    applyStimulus();
    swResetReq = 1'b0;
    checkOutput("soft_periph_k", periphRst, 1'b1);
    checkOutput("soft_core_k", coreRst, 1'b1);
    for (int j = 1; j <= 12; j++) begin
      applyStimulus();
      checkOutput("soft_ready", clkReady, 1'b1);
      if (j == 7)  checkOutput("soft_periph_k7", periphRst, 1'b1);
      if (j == 8)  checkOutput("soft_periph_k8", periphRst, 1'b0);
      if (j == 11) checkOutput("soft_core_k11", coreRst, 1'b1);
      if (j == 12) checkOutput("soft_core_k12", coreRst, 1'b0);
    end

    // Request held for 20 cycles: one soft sequence per visit to RUN.
    softEntries = 0;
    swResetReq  = 1'b1;
    for (int j = 0; j < 20; j++) begin
      prevPeriph = periphRst;
      applyStimulus();
      if (!prevPeriph && periphRst) softEntries++;
    end
    swResetReq = 1'b0;
    checkOutput("held_two_entries", (softEntries == 2), 1'b1);
    for (int j = 0; j < 10; j++) applyStimulus();

    // Lock loss in RUN, m = first edge sampling lock low.
    pllLock = 1'b0;
    applyStimulus();
    checkOutput("loss_core_m", coreRst, 1'b0);
    applyStimulus();
    checkOutput("loss_core_m1", coreRst, 1'b0);
    applyStimulus();
    checkOutput("loss_core_m2", coreRst, 1'b1);
    checkOutput("loss_periph_m2", periphRst, 1'b1);
    checkOutput("loss_ready_m2", clkReady, 1'b0);
    checkOutput("loss_flag_m2", lockLost, 1'b1);
    pllLock = 1'b1;
    for (int j = 0; j < 30; j++) applyStimulus();
    checkOutput("loss_flag_sticky", lockLost, 1'b1);

    // One-cycle lock glitch during STABLE restarts the settling count.
    pulseReset();
    for (int e = 1; e <= 45; e++) begin
      pllLock = (e == 14) ? 1'b0 : 1'b1;
      applyStimulus();
      if (e == 32) checkOutput("glitch_periph_e32", periphRst, 1'b1);
      if (e == 33) checkOutput("glitch_periph_e33", periphRst, 1'b0);
      if (e == 36) checkOutput("glitch_core_e36", coreRst, 1'b1);
      if (e == 37) checkOutput("glitch_core_e37", coreRst, 1'b0);
    end
    checkOutput("glitch_no_lost", lockLost, 1'b0);

    // Asynchronous reset in the middle of PERIPH.
    pulseReset();
    pllLock = 1'b1;
    for (int e = 1; e <= 20; e++) applyStimulus();
    checkOutput("pre_async_periph", periphRst, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("async_periph", periphRst, 1'b1);
    checkOutput("async_core", coreRst, 1'b1);
    checkOutput("async_ready", clkReady, 1'b0);
    checkOutput("async_lost", lockLost, 1'b0);
    modelReset();
    applyStimulus();
    reset = 1'b0;

    // Random lock drops, soft requests and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 599) == 0) reset = 1'b1;
      if (pllLock) pllLock = ($urandom_range(0, 79) != 0);
      else pllLock = ($urandom_range(0, 3) == 0);
      swResetReq = ($urandom_range(0, 9) == 0);
      applyStimulus();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
